// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with MEM/WB bypass and load-use stall.
// Operands are resolved every cycle from the held fields and the live forwarding buses.
package id_ex_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_t;
endpackage

module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_t             in_alu_op,
    input  logic [4:0]       in_rs1_addr,
    input  logic [4:0]       in_rs2_addr,
    input  logic [4:0]       in_rd_addr,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [1:0]       in_src_a_sel,
    input  logic [1:0]       in_src_b_sel,
    input  logic             in_reg_write,
    input  logic             fwd_mem_en,
    input  logic [4:0]       fwd_mem_rd,
    input  logic [WIDTH-1:0] fwd_mem_data,
    input  logic             fwd_mem_pending,
    input  logic             fwd_wb_en,
    input  logic [4:0]       fwd_wb_rd,
    input  logic [WIDTH-1:0] fwd_wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_t             alu_op,
    output logic [WIDTH-1:0] alu_opA,
    output logic [WIDTH-1:0] alu_opB,
    output logic [WIDTH-1:0] rs2_data,
    output logic [4:0]       rd_addr,
    output logic             reg_write
);
    logic             valid_q;
    alu_t             op_q;
    logic [4:0]       rs1_addr_q, rs2_addr_q, rd_q;
    logic [WIDTH-1:0] rs1_val_q, rs2_val_q, imm_q, pc_q;
    logic [1:0]       a_sel_q, b_sel_q;
    logic             rw_q;
    logic             mem1, mem2, wb1, wb2, hazard, load;
    logic [WIDTH-1:0] rs1_fwd, rs2_fwd;

    always_comb begin
        mem1 = fwd_mem_en && fwd_mem_rd == rs1_addr_q && rs1_addr_q != 5'd0;
        mem2 = fwd_mem_en && fwd_mem_rd == rs2_addr_q && rs2_addr_q != 5'd0;
        wb1 = fwd_wb_en && fwd_wb_rd == rs1_addr_q && rs1_addr_q != 5'd0;
        wb2 = fwd_wb_en && fwd_wb_rd == rs2_addr_q && rs2_addr_q != 5'd0;
        rs1_fwd = mem1 ? fwd_mem_data : wb1 ? fwd_wb_data : rs1_val_q;
        rs2_fwd = mem2 ? fwd_mem_data : wb2 ? fwd_wb_data : rs2_val_q;
        // rs2 always counts as used because it feeds the store data path
        hazard = valid_q && fwd_mem_pending && ((mem1 && a_sel_q == 2'b00) || mem2);
        out_valid = valid_q && !hazard;
        in_ready = !valid_q || (out_ready && out_valid);
        load = in_valid && in_ready && !flush;
        alu_opA = a_sel_q == 2'b00 ? rs1_fwd : a_sel_q == 2'b01 ? pc_q : '0;
        alu_opB = b_sel_q == 2'b00 ? rs2_fwd : b_sel_q == 2'b01 ? imm_q :
                  b_sel_q == 2'b10 ? WIDTH'(4) : '0;
    end

    assign alu_op    = op_q;
    assign rs2_data  = rs2_fwd;
    assign rd_addr   = rd_q;
    assign reg_write = rw_q && out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            op_q       <= ALU_ADD;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            a_sel_q    <= '0;
            b_sel_q    <= '0;
            rw_q       <= 1'b0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (load)
                valid_q <= 1'b1;
            else if (out_valid && out_ready)
                valid_q <= 1'b0;
            if (load) begin
                op_q       <= in_alu_op;
                rs1_addr_q <= in_rs1_addr;
                rs2_addr_q <= in_rs2_addr;
                rd_q       <= in_rd_addr;
                rs1_val_q  <= in_rs1_val;
                rs2_val_q  <= in_rs2_val;
                imm_q      <= in_imm;
                pc_q       <= in_pc;
                a_sel_q    <= in_src_a_sel;
                b_sel_q    <= in_src_b_sel;
                rw_q       <= in_reg_write;
            end else if (valid_q) begin
                // absorb retiring WB results so the operand survives after WB moves on
                if (wb1 && !mem1)
                    rs1_val_q <= fwd_wb_data;
                if (wb2 && !mem2)
                    rs2_val_q <= fwd_wb_data;
            end
        end
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the RV32 core, sitting directly upstream of the `alu`. It accepts one decoded instruction per valid/ready handshake, holds it across downstream stalls and flushes, and drives the ALU's `op`, `opA` and `opB`. Operands are resolved every cycle through a MEM/WB bypass network. The block also detects the load-use hazard and withholds `out_valid` until the loaded data is available.

## Interface
- `WIDTH`, 32, datapath width.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard the held instruction and the incoming one.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage can accept.
- `in_alu_op` in `alu_t`: ALU operation.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in 5 each: register indices.
- `in_rs1_val`, `in_rs2_val`, `in_imm`, `in_pc` in WIDTH each: register-file reads, immediate and PC.
- `in_src_a_sel` in 2: operand A select; 00 = rs1, 01 = pc, 10 = zero, 11 = zero.
- `in_src_b_sel` in 2: operand B select; 00 = rs2, 01 = imm, 10 = constant 4, 11 = zero.
- `in_reg_write` in 1: instruction writes rd.
- `fwd_mem_en` in 1: MEM stage writes a register.
- `fwd_mem_rd` in 5: MEM destination register.
- `fwd_mem_data` in WIDTH: MEM result.
- `fwd_mem_pending` in 1: the MEM result is a load whose data is not yet valid.
- `fwd_wb_en`, `fwd_wb_rd`, `fwd_wb_data`: same meaning for the WB stage; WB data is always valid.
- `out_valid` out 1: the ALU inputs are valid this cycle.
- `out_ready` in 1: execute consumes this cycle.
- `alu_op` out `alu_t`: drives `alu.op`.
- `alu_opA`, `alu_opB` out WIDTH: drive `alu.opA` and `alu.opB`.
- `rs2_data` out WIDTH: forwarded rs2 value, used as store data.
- `rd_addr` out 5: held destination register.
- `reg_write` out 1: held write enable, gated by `out_valid`.

## Operation
- Registered state:
  - `valid_q`, op, rs addresses and values, rd, imm, pc, selects, reg_write.
  - At reset all are 0, and op resets to `ALU_ADD`.
- `in_ready = !valid_q || (out_ready && out_valid)`.
- Load: when `in_valid && in_ready && !flush`, all fields are captured and `valid_q` is set to 1.
- Consume: on `out_valid && out_ready` with no new load, `valid_q` is set to 0.
- Flush:
  - Has priority over load and consume.
  - Next cycle `valid_q = 0`; the incoming instruction is dropped.
  - `in_ready` is unaffected.
- Bypass, for each of rs1 and rs2 and evaluated combinationally from the held addresses:
  - Address x0 yields the held value (0 in practice) and never forwards.
  - MEM match (`fwd_mem_en && fwd_mem_rd == addr`) takes `fwd_mem_data`.
  - Otherwise a WB match takes `fwd_wb_data`.
  - Otherwise the held register value is used.
  - MEM has priority over WB.
- WB capture:
  - While `valid_q` is set and the stage is not being reloaded, a WB match with no MEM match writes `fwd_wb_data` into the held rs value.
  - This keeps the value correct after WB retires.
- Load-use hazard:
  - `hazard = valid_q && fwd_mem_pending && fwd_mem_en`, and the MEM rd (nonzero) matches an rs that is used.
  - rs1 counts as used when `src_a_sel == 00`.
  - rs2 counts as used when `src_b_sel == 00`, or always for `rs2_data`.
  - `out_valid = valid_q && !hazard`.
  - While the hazard holds, `in_ready = 0` whenever `valid_q` is set.
- Operand mux:
  - `alu_opA` is the forwarded rs1, pc or 0 according to `src_a_sel`.
  - `alu_opB` is the forwarded rs2, imm, 32'd4 or 0 according to `src_b_sel`.
  - `rs2_data` is always the forwarded rs2.
- Outputs are driven from the held fields even when `out_valid = 0`; the consumer qualifies them.

## Timing
- Latency: an instruction accepted on edge N presents `out_valid = 1` after edge N.
- Throughput: one instruction per cycle when `out_ready` stays high (pass-through).
- Output paths: `alu_opA`, `alu_opB`, `rs2_data` and `out_valid` are combinational from the registers and the `fwd_*` inputs. `in_ready` is combinational from `out_ready` and the hazard.
- Reset: asserting `rst_n` low at any time, including mid-stall, forces `valid_q = 0`, `in_ready = 1`, `out_valid = 0` and `reg_write = 0` immediately, with all data outputs at 0.
- Simultaneous events:
  - Consume and load on the same edge replace the held instruction.
  - Flush together with `in_valid` results in empty.
  - Hazard together with flush results in empty.

## Test plan
- Reset and pass-through:
  - Stimulus: reset, then ADD with rs1 = 5 and rs2 = 7 from the register file, no forwarding matches, `out_ready = 1`.
  - Required: one cycle later `out_valid = 1`, `alu_op = ALU_ADD`, `opA = 5`, `opB = 7`; back-to-back issue sustains 1 per cycle.
- Forward priority:
  - Stimulus: rs1 = x3 held as 1, MEM rd = 3 with data 0xAA, WB rd = 3 with data 0xBB.
  - Required: `opA = 0xAA`. With MEM disabled, `opA = 0xBB`. With rs1 = x0 and both matching x0, `opA = 0`.
- Stall with WB capture:
  - Stimulus: `out_ready = 0` with WB rd = rs2 and data 0x1234 for one cycle, then WB idle.
  - Required: `opB` stays 0x1234 on later cycles, and `in_ready = 0` throughout the stall.
- Load-use:
  - Stimulus: `fwd_mem_pending = 1` with MEM rd = rs1 = x4 and `src_a_sel = 00` for 2 cycles.
  - Required: `out_valid = 0` and `in_ready = 0` during those 2 cycles; when pending drops, `out_valid = 1` with the MEM data.
  - Also required: with `src_a_sel = 01` (pc) and rs2 not x4, there is no stall.
- Flush:
  - Stimulus: assert `flush` together with `in_valid` while an instruction is held and `out_ready = 0`.
  - Required: next cycle `out_valid = 0` and `reg_write = 0`; the following accept works normally.
- Immediate/PC selects:
  - Stimulus: `src_a = 01` with pc = 0x100, `src_b = 10`.
  - Required: `opA = 0x100`, `opB = 4`.
  - Stimulus: `src_b = 01` with imm = 0xFFFFFFF0.
  - Required: `opB = 0xFFFFFFF0`.
